projeto_200917_qsys_led_seq: RTL
================================

// Module: projeto_200917_qsys_led_seq
// PURPOSE
//  Avalon-MM slave that owns the green-LED output and sequences it. The CPU either writes a manual
//  value (PIO-compatible at offset 0) or loads up to DEPTH patterns and starts autonomous playback.
//  Each pattern is held for DIVIDER+1 clocks, with one-shot or loop modes and a done interrupt.
//  Sits in the Qsys system in place of a plain output PIO; out_port drives the LEDs directly.
// PARAMETERS
//  DATA_W     8         width of out_port and of each pattern/manual register
//  DEPTH      8         pattern slots (max 8; slot addresses 8..8+DEPTH-1)
//  DIV_W      24        prescaler width
//  DIV_RESET  24'd4999  DIVIDER reset value
// PORTS
//  clk         in   1       system clock; single clock domain
//  reset       in   1       synchronous, active-high reset
//  address     in   4       word offset
//  chipselect  in   1       slave select
//  write_n     in   1       active-low write strobe; write accepted when chipselect && !write_n
//  writedata   in   32      write data
//  readdata    out  32      combinational read mux, zero wait states, zero-extended
//  out_port    out  DATA_W  LED drive
//  irq         out  1       DONE & CTRL.IRQ_EN
// BEHAVIOUR
//  Register map:
//   0 MANUAL   rw [DATA_W-1:0]
//   1 CTRL     rw b0 RUN, b1 LOOP, b2 IRQ_EN
//   2 STATUS   r  b0 BUSY, b1 DONE, [6:4] IDX; write b1=1 clears DONE
//   3 DIVIDER  rw [DIV_W-1:0]
//   4 LENGTH   rw [3:0]; write 0 stores 1, write >DEPTH stores DEPTH
//   8.. PATTERN[i] rw
//  Unmapped offsets read 0; writes to them are ignored.
//  Reset: MANUAL=0, CTRL=0, DONE=0, IDX=0, DIVIDER=DIV_RESET, LENGTH=1, PATTERN[*]=0, state=IDLE.
//   Consequently out_port=0, irq=0 and readdata reflects reset values.
//  FSM:
//   IDLE: out_port=MANUAL; BUSY=0. A CTRL write with RUN=1 -> RUN, IDX=0, cnt=DIVIDER.
//   RUN:  out_port=PATTERN[IDX]; BUSY=1; cnt decrements each clk. At cnt==0 (tick):
//    - if IDX>=LENGTH-1 and LOOP=1: IDX=0.
//    - if IDX>=LENGTH-1 and LOOP=0: -> HOLD, DONE=1, CTRL.RUN auto-cleared.
//    - otherwise: IDX+1.
//    cnt reloads from DIVIDER on every tick. Writing CTRL with RUN=0 -> IDLE, IDX=0 (abort; DONE unchanged).
//   HOLD: out_port=PATTERN[LENGTH-1], held. A CTRL write with RUN=1 -> RUN at IDX 0; RUN=0 -> IDLE.
//  Timing: registers and state update on the accepting edge, so out_port changes on that same edge
//   (same as the PIO data register). PATTERN[0] shows for exactly DIVIDER+1 clks; DIVIDER=0 gives 1 clk/pattern.
//  Live edits in RUN:
//   - DIVIDER write: takes effect at the next reload only.
//   - PATTERN write to the displayed slot: visible the next clk.
//   - LENGTH reduced below IDX+1: treated as last slot at the next tick (no out-of-range index).
//  Simultaneous events: a CTRL write wins over a tick in the same cycle. A STATUS DONE-clear in the
//   same cycle as DONE being set leaves DONE=1.
//  reset asserted mid-playback: full reset values at the next edge, regardless of state.
//  Only writedata[DATA_W-1:0] / the listed fields are stored; upper bits are ignored.
// STRUCTURE
//  projeto_200917_qsys_led_seq_defs.vh: register offsets, CTRL/STATUS bit positions, state encodings
//   IDLE=2'd0, RUN=2'd1, HOLD=2'd2 (2'd3 recovers to IDLE).
//  Sub-module projeto_200917_qsys_led_seq_prescaler (DIV_W): inputs load, en, reload value;
//   output one-cycle tick.
//  Top level holds the register file, pattern array, FSM and read mux.
// TESTING
//  1 Reset, read all regs -> DIVIDER=DIV_RESET, LENGTH=1, others 0; out_port=0.
//  2 Write MANUAL=8'hA5 -> out_port=8'hA5 after the write edge; readdata[31:0]=32'h000000A5.
//  3 PATTERN[0..2]=01,02,04; LENGTH=3; DIVIDER=3; CTRL=1 -> out_port 01,02,04 for 4 clks each,
//    then HOLD with 04, DONE=1, CTRL reads 0.
//  4 As 3 with CTRL=3'b111 -> sequence repeats 01,02,04,01..., irq stays 0; clear RUN mid-run ->
//    out_port=MANUAL next clk, IDX=0.
//  5 Write LENGTH=0 -> reads 1; write LENGTH=15 -> reads 8. In RUN at IDX=5, write LENGTH=2 ->
//    next tick wraps/stops per LOOP.
//  6 Assert reset for 1 clk during RUN at IDX=2 -> IDLE, out_port=0, irq=0; CTRL write on a tick
//    cycle -> CTRL wins.

Source files
------------

// File: rtl/projeto_200917_qsys_led_seq_pkg.sv
// Shared register offsets, field positions and FSM encoding for the LED sequencer.
package projeto_200917_qsys_led_seq_pkg;

    localparam logic [3:0] AddrManual  = 4'd0;
    localparam logic [3:0] AddrCtrl    = 4'd1;
    localparam logic [3:0] AddrStatus  = 4'd2;
    localparam logic [3:0] AddrDivider = 4'd3;
    localparam logic [3:0] AddrLength  = 4'd4;

    localparam int unsigned CtrlRun      = 0;
    localparam int unsigned CtrlLoop     = 1;
    localparam int unsigned CtrlIrqEn    = 2;
    localparam int unsigned StatusBusy   = 0;
    localparam int unsigned StatusDone   = 1;
    localparam int unsigned StatusIdxLsb = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } seq_state_e;

    // LENGTH is never 0 and never larger than the pattern store.
    function automatic logic [3:0] clamp_length(input logic [3:0] req, input logic [3:0] depth);
        if (req == 4'd0) begin
            return 4'd1;
        end else if (req > depth) begin
            return depth;
        end
        return req;
    endfunction

endpackage

// File: rtl/projeto_200917_qsys_led_seq_prescaler.sv
// Down-counting prescaler: tick is high for the single cycle in which the count sits at zero.
module projeto_200917_qsys_led_seq_prescaler #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= reload;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/projeto_200917_qsys_led_seq.sv
// Avalon-MM LED sequencer: manual PIO-compatible output or timed playback of stored patterns.
module projeto_200917_qsys_led_seq
    import projeto_200917_qsys_led_seq_pkg::*;
#(
    parameter int unsigned      DATA_W    = 8,
    parameter int unsigned      DEPTH     = 8,
    parameter int unsigned      DIV_W     = 24,
    parameter logic [DIV_W-1:0] DIV_RESET = 24'd4999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);

    localparam logic [3:0] DepthL = 4'(DEPTH);

    logic [DATA_W-1:0] manual;
    logic              run;
    logic              loop_mode;
    logic              irq_en;
    logic              done;
    logic [2:0]        idx;
    logic [DIV_W-1:0]  divider;
    logic [3:0]        length;
    logic [DATA_W-1:0] pattern [DEPTH];
    seq_state_e        state;

    logic       wr_en;
    logic       ctrl_wr;
    logic       pat_sel;
    logic       tick;
    logic       last_slot;
    logic [2:0] hold_idx;

    assign wr_en     = chipselect && !write_n;
    assign ctrl_wr   = wr_en && (address == AddrCtrl);
    assign pat_sel   = address[3] && ({1'b0, address[2:0]} < DepthL);
    // A shortened LENGTH makes the current slot the last one instead of indexing past it.
    assign last_slot = ({1'b0, idx} + 4'd1) >= length;
    assign hold_idx  = length[2:0] - 3'd1;
    assign irq       = done && irq_en;

    if (DIV_W < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:DIV_W];
    end

    projeto_200917_qsys_led_seq_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .load   (ctrl_wr && writedata[CtrlRun]),
        .en     (state == StRun),
        .reload (divider),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            manual    <= '0;
            run       <= 1'b0;
            loop_mode <= 1'b0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            idx       <= '0;
            divider   <= DIV_RESET;
            length    <= 4'd1;
            state     <= StIdle;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pattern[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                case (address)
                    AddrManual:  manual  <= writedata[DATA_W-1:0];
                    AddrDivider: divider <= writedata[DIV_W-1:0];
                    AddrLength:  length  <= clamp_length(writedata[3:0], DepthL);
                    AddrStatus: begin
                        if (writedata[StatusDone]) begin
                            done <= 1'b0;
                        end
                    end
                    default: begin
                        if (pat_sel) begin
                            pattern[address[2:0]] <= writedata[DATA_W-1:0];
                        end
                    end
                endcase
            end

            // A CTRL write pre-empts any tick in the same cycle; a DONE set below
            // overrides a same-cycle DONE clear above.
            if (ctrl_wr) begin
                run       <= writedata[CtrlRun];
                loop_mode <= writedata[CtrlLoop];
                irq_en    <= writedata[CtrlIrqEn];
                idx       <= '0;
                state     <= writedata[CtrlRun] ? StRun : StIdle;
            end else begin
                case (state)
                    StIdle: ;
                    StRun: begin
                        if (tick) begin
                            if (!last_slot) begin
                                idx <= idx + 3'd1;
                            end else if (loop_mode) begin
                                idx <= '0;
                            end else begin
                                state <= StHold;
                                done  <= 1'b1;
                                run   <= 1'b0;
                            end
                        end
                    end
                    StHold: ;
                    default: state <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        out_port = manual;
        case (state)
            StRun:   out_port = pattern[idx];
            StHold:  out_port = pattern[hold_idx];
            default: out_port = manual;
        endcase
    end

    always_comb begin
        readdata = '0;
        case (address)
            AddrManual:  readdata[DATA_W-1:0] = manual;
            AddrCtrl:    readdata[2:0] = {irq_en, loop_mode, run};
            AddrStatus: begin
                readdata[StatusBusy]                     = (state == StRun);
                readdata[StatusDone]                     = done;
                readdata[StatusIdxLsb+2:StatusIdxLsb]    = idx;
            end
            AddrDivider: readdata[DIV_W-1:0] = divider;
            AddrLength:  readdata[3:0] = length;
            default: begin
                if (pat_sel) begin
                    readdata[DATA_W-1:0] = pattern[address[2:0]];
                end
            end
        endcase
    end

endmodule
